// File: rtl/inst_fetch_fifo_if.sv
// Fetch-to-decode instruction buffer bus: fetch push side, decode presentation side and back-end flush.
// The master modport is the buffer itself; the slave modport is the surrounding pipeline.
interface inst_fetch_fifo_if;
  logic        flush;

  logic        if_readygo;
  logic        if_allowin;
  logic [1:0]  if_valid;
  logic [31:0] if_pc0;
  logic [31:0] if_pc1;
  logic [31:0] if_inst0;
  logic [31:0] if_inst1;
  logic [1:0]  if_excp;
  logic [6:0]  if_exception0;
  logic [6:0]  if_exception1;
  logic [1:0]  if_priv;

  logic        id_readygo;
  logic        id_allowin;
  logic [31:0] fifo_id_pc0;
  logic [31:0] fifo_id_pc1;
  logic [31:0] fifo_id_inst0;
  logic [31:0] fifo_id_inst1;
  logic [31:0] fifo_id_badv;
  logic [1:0]  fifo_id_excp_flag;
  logic [6:0]  fifo_id_exception;
  logic [1:0]  fifo_id_priv_flag;

  modport master (
    input  flush, if_readygo, if_valid, if_pc0, if_pc1, if_inst0, if_inst1,
           if_excp, if_exception0, if_exception1, if_priv, id_allowin,
    output if_allowin, id_readygo, fifo_id_pc0, fifo_id_pc1, fifo_id_inst0,
           fifo_id_inst1, fifo_id_badv, fifo_id_excp_flag, fifo_id_exception,
           fifo_id_priv_flag
  );

  modport slave (
    output flush, if_readygo, if_valid, if_pc0, if_pc1, if_inst0, if_inst1,
           if_excp, if_exception0, if_exception1, if_priv, id_allowin,
    input  if_allowin, id_readygo, fifo_id_pc0, fifo_id_pc1, fifo_id_inst0,
           fifo_id_inst1, fifo_id_badv, fifo_id_excp_flag, fifo_id_exception,
           fifo_id_priv_flag
  );
endinterface

// File: rtl/inst_fetch_fifo.sv
// Instruction buffer between fetch and dual-issue decode: takes up to two instructions per cycle,
// presents up to two in order, issues priv/exception instructions alone with a NOP-padded slot1.
module inst_fetch_fifo #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] NOP_INST = 32'h0340_0000
) (
  input logic               aclk,
  input logic               areset,
  inst_fetch_fifo_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        excp;
    logic [6:0]  code;
    logic        priv;
  } entry_t;

  // Room for a full two-instruction packet is required, whatever decode does this cycle.
  localparam cnt_t ALLOW_MAX = cnt_t'(DEPTH - 2);

  entry_t     mem [DEPTH];
  ptr_t       head;
  ptr_t       tail;
  cnt_t       count;

  ptr_t       head_nx;
  entry_t     e0;
  entry_t     e1;
  entry_t     in0;
  entry_t     in1;
  logic       single;
  logic       do_push;
  logic       do_pop;
  logic [1:0] push_n;
  logic [1:0] pop_n;

  assign head_nx = head + ptr_t'(1);
  assign e0      = mem[head];
  assign e1      = mem[head_nx];

  assign in0 = '{pc: bus.if_pc0, inst: bus.if_inst0, excp: bus.if_excp[0],
                 code: bus.if_exception0, priv: bus.if_priv[0]};
  assign in1 = '{pc: bus.if_pc1, inst: bus.if_inst1, excp: bus.if_excp[1],
                 code: bus.if_exception1, priv: bus.if_priv[1]};

  assign bus.if_allowin = (count <= ALLOW_MAX) && !bus.flush;
  assign bus.id_readygo = (count != '0) && !bus.flush;

  assign single  = (count == cnt_t'(1)) || e0.priv || e0.excp || e1.priv;
  assign do_push = bus.if_readygo && bus.if_allowin;
  assign do_pop  = bus.id_readygo && bus.id_allowin;
  assign push_n  = do_push ? ({1'b0, bus.if_valid[0]} + {1'b0, bus.if_valid[1]}) : 2'd0;
  assign pop_n   = do_pop ? (single ? 2'd1 : 2'd2) : 2'd0;

  // NOTE: the storage array has no reset; only head/tail/count define which entries are live,
  // so clearing the data would cost flops and buy nothing.
  always_ff @(posedge aclk) begin
    if (do_push && (bus.if_valid != 2'b00)) begin
      mem[tail] <= bus.if_valid[0] ? in0 : in1;
      if (bus.if_valid == 2'b11) begin
        mem[tail + ptr_t'(1)] <= in1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every pointer samples pre-edge values.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + ptr_t'(pop_n);
      tail  <= tail + ptr_t'(push_n);
      count <= count + cnt_t'(push_n) - cnt_t'(pop_n);
    end
  end

  // NOTE: every output gets a default first so this block can never infer a latch.
  always_comb begin
    bus.fifo_id_pc0       = '0;
    bus.fifo_id_pc1       = '0;
    bus.fifo_id_inst0     = '0;
    bus.fifo_id_inst1     = '0;
    bus.fifo_id_badv      = '0;
    bus.fifo_id_excp_flag = '0;
    bus.fifo_id_exception = '0;
    bus.fifo_id_priv_flag = '0;
    if (bus.id_readygo) begin
      bus.fifo_id_pc0          = e0.pc;
      bus.fifo_id_inst0        = e0.inst;
      bus.fifo_id_excp_flag[0] = e0.excp;
      bus.fifo_id_priv_flag[0] = e0.priv;
      if (single) begin
        bus.fifo_id_pc1   = e0.pc + 32'd4;
        bus.fifo_id_inst1 = NOP_INST;
      end else begin
        bus.fifo_id_pc1          = e1.pc;
        bus.fifo_id_inst1        = e1.inst;
        bus.fifo_id_excp_flag[1] = e1.excp;
        bus.fifo_id_priv_flag[1] = e1.priv;
      end
      // The oldest excepting slot supplies badv and the code.
      if (e0.excp) begin
        bus.fifo_id_badv      = e0.pc;
        bus.fifo_id_exception = e0.code;
      end else if (!single && e1.excp) begin
        bus.fifo_id_badv      = e1.pc;
        bus.fifo_id_exception = e1.code;
      end
    end
  end
endmodule
